// File: rtl/seven_seg_capture_if.sv
// Seven-segment capture bus.
// Groups the multiplexed display lines seen by the capture block together with
// the digits and status it recovers from them.
//   an          : digit enables, active-low (driven by the display side)
//   seg         : segment lines {g..a}, active-low (driven by the display side)
//   hex         : recovered digits, digit i in hex[4i+3:4i]
//   digit_valid : digit i holds a legally decoded value
//   err         : last accepted pattern on digit i was not a legal glyph
//   frame_done  : one-cycle pulse when all four digits were freshly accepted
// master = display/driver side, slave = capture block.
interface seven_seg_capture_if;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] hex;
  logic [3:0]  digit_valid;
  logic [3:0]  err;
  logic        frame_done;

  modport master (
    output an, seg,
    input  hex, digit_valid, err, frame_done
  );

  modport slave (
    input  an, seg,
    output hex, digit_valid, err, frame_done
  );
endinterface

// File: rtl/seven_seg_capture.sv
// Seven-segment display capture.
// Snoops a multiplexed, active-low 4-digit seven-segment display and recovers
// the hexadecimal digits being shown.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : seven_seg_capture_if.slave (an/seg in, hex/digit_valid/err/frame_done out)
// Parameter:
//   STABLE_CYCLES : identical synchronized samples needed to accept a digit (2..15)
module seven_seg_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  seven_seg_capture_if.slave  bus
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

  // {legal, nibble} for an active-low segment pattern.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg_n);
    logic [6:0] pat;
    logic [4:0] r;
    pat = ~seg_n;
    case (pat)
      7'h3F:   r = 5'h10;
      7'h06:   r = 5'h11;
      7'h5B:   r = 5'h12;
      7'h4F:   r = 5'h13;
      7'h66:   r = 5'h14;
      7'h6D:   r = 5'h15;
      7'h7D:   r = 5'h16;
      7'h07:   r = 5'h17;
      7'h7F:   r = 5'h18;
      7'h6F:   r = 5'h19;
      7'h77:   r = 5'h1A;
      7'h7C:   r = 5'h1B;
      7'h39:   r = 5'h1C;
      7'h5E:   r = 5'h1D;
      7'h79:   r = 5'h1E;
      7'h71:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // {exactly-one-enable-low, digit index}.
  function automatic logic [2:0] digit_info(input logic [3:0] an_n);
    logic [2:0] r;
    case (an_n)
      4'b1110: r = 3'b100;
      4'b1101: r = 3'b101;
      4'b1011: r = 3'b110;
      4'b0111: r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  logic [3:0]  an_s1_q, an_s1_d, an_s2_q, an_s2_d;
  logic [6:0]  seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [3:0]  an_st_q, an_st_d;
  logic [6:0]  seg_st_q, seg_st_d;
  logic        acc_q, acc_d;
  logic [1:0]  acc_idx_q, acc_idx_d;
  logic [4:0]  acc_code_q, acc_code_d;
  logic [15:0] hex_q, hex_d;
  logic [3:0]  dv_q, dv_d;
  logic [3:0]  err_q, err_d;
  logic [3:0]  seen_q, seen_d;
  logic        fd_q, fd_d;

  logic [2:0]  an_info;
  logic        same_pair;

  // Stage 1/2: two-flop synchronizer on the display lines.
  always_comb begin
    an_s1_d  = bus.an;
    seg_s1_d = bus.seg;
    an_s2_d  = an_s1_q;
    seg_s2_d = seg_s1_q;
  end

  // Stage 3: stability tracking FSM on synchronized samples.
  always_comb begin
    an_info   = digit_info(an_s2_q);
    same_pair = (an_s2_q == an_st_q) && (seg_s2_q == seg_st_q);

    state_d    = state_q;
    count_d    = count_q;
    an_st_d    = an_st_q;
    seg_st_d   = seg_st_q;
    acc_d      = 1'b0;
    acc_idx_d  = acc_idx_q;
    acc_code_d = acc_code_q;

    if (!an_info[2]) begin
      state_d = IDLE;
      count_d = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = TRACK;
          count_d  = 4'd1;
          an_st_d  = an_s2_q;
          seg_st_d = seg_s2_q;
        end
        TRACK: begin
          if (same_pair) begin
            count_d = (count_q >= CNT_MAX) ? CNT_MAX : count_q + 4'd1;
            if (count_d == CNT_MAX) begin
              state_d    = LOCKED;
              acc_d      = 1'b1;
              acc_idx_d  = an_info[1:0];
              acc_code_d = decode_glyph(seg_s2_q);
            end
          end else begin
            count_d  = 4'd1;
            an_st_d  = an_s2_q;
            seg_st_d = seg_s2_q;
          end
        end
        LOCKED: begin
          if (!same_pair) begin
            state_d  = TRACK;
            count_d  = 4'd1;
            an_st_d  = an_s2_q;
            seg_st_d = seg_s2_q;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = 4'd0;
        end
      endcase
    end
  end

  // Stage 4: commit accepted digit to outputs and frame tracking.
  always_comb begin
    hex_d  = hex_q;
    dv_d   = dv_q;
    err_d  = err_q;
    seen_d = seen_q;
    fd_d   = 1'b0;
    if (acc_q) begin
      if (acc_code_q[4]) begin
        hex_d[{acc_idx_q, 2'b00} +: 4] = acc_code_q[3:0];
        dv_d[acc_idx_q]                = 1'b1;
        err_d[acc_idx_q]               = 1'b0;
      end else begin
        dv_d[acc_idx_q]  = 1'b0;
        err_d[acc_idx_q] = 1'b1;
      end
      seen_d = seen_q | (4'b0001 << acc_idx_q);
      // Completing the frame restarts collection on the same edge.
      if (seen_d == 4'hF) begin
        seen_d = 4'h0;
        fd_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an_s1_q    <= 4'hF;
      an_s2_q    <= 4'hF;
      seg_s1_q   <= 7'h7F;
      seg_s2_q   <= 7'h7F;
      state_q    <= IDLE;
      count_q    <= 4'd0;
      an_st_q    <= 4'hF;
      seg_st_q   <= 7'h7F;
      acc_q      <= 1'b0;
      acc_idx_q  <= 2'd0;
      acc_code_q <= 5'd0;
      hex_q      <= 16'h0000;
      dv_q       <= 4'h0;
      err_q      <= 4'h0;
      seen_q     <= 4'h0;
      fd_q       <= 1'b0;
    end else begin
      an_s1_q    <= an_s1_d;
      an_s2_q    <= an_s2_d;
      seg_s1_q   <= seg_s1_d;
      seg_s2_q   <= seg_s2_d;
      state_q    <= state_d;
      count_q    <= count_d;
      an_st_q    <= an_st_d;
      seg_st_q   <= seg_st_d;
      acc_q      <= acc_d;
      acc_idx_q  <= acc_idx_d;
      acc_code_q <= acc_code_d;
      hex_q      <= hex_d;
      dv_q       <= dv_d;
      err_q      <= err_d;
      seen_q     <= seen_d;
      fd_q       <= fd_d;
    end
  end

  assign bus.hex         = hex_q;
  assign bus.digit_valid = dv_q;
  assign bus.err         = err_q;
  assign bus.frame_done  = fd_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Testbench for seven_seg_capture: latency sequence, table of display
// patterns checked through a scoreboard queue, and a mid-capture reset.
module tb_seven_seg_capture;

  logic clk;
  logic reset;

  seven_seg_capture_if bus();

  seven_seg_capture #(.STABLE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    int          hold;
    logic [15:0] hex;
    logic [3:0]  dv;
    logic [3:0]  err;
    int          fd;
  } vec_t;

  vec_t vecs[17];
  vec_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] an, input logic [6:0] pat, input int hold,
                              input logic [15:0] hex, input logic [3:0] dv,
                              input logic [3:0] err, input int fd);
    vec_t v;
    v.an = an; v.seg = ~pat; v.hold = hold;
    v.hex = hex; v.dv = dv; v.err = err; v.fd = fd;
    return v;
  endfunction

  // Drive one pattern (called at a negedge), count frame_done pulses while it
  // is held, then compare against the expectation popped from the scoreboard.
  task automatic run_vec(input int idx);
    vec_t v;
    vec_t e;
    int   fd_cnt;
    v = vecs[idx];
    bus.an  = v.an;
    bus.seg = v.seg;
    sb_q.push_back(v);
    fd_cnt = 0;
    repeat (v.hold) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.frame_done) fd_cnt++;
    end
    e = sb_q.pop_front();
    check($sformatf("vec%0d_hex", idx), 32'(bus.hex), 32'(e.hex));
    check($sformatf("vec%0d_valid", idx), 32'(bus.digit_valid), 32'(e.dv));
    check($sformatf("vec%0d_err", idx), 32'(bus.err), 32'(e.err));
    check($sformatf("vec%0d_frame_done_pulses", idx), 32'(fd_cnt), 32'(e.fd));
  endtask

  initial begin
    //              an     glyph  hold  hex       valid  err   fd
    vecs[0]  = mk(4'hE, 7'h06, 8,  16'h0001, 4'h1, 4'h0, 0);
    vecs[1]  = mk(4'hE, 7'h4F, 8,  16'h0003, 4'h1, 4'h0, 0);
    vecs[2]  = mk(4'hD, 7'h77, 8,  16'h00A3, 4'h3, 4'h0, 0);
    vecs[3]  = mk(4'hB, 7'h7C, 8,  16'h0BA3, 4'h7, 4'h0, 0);
    vecs[4]  = mk(4'h7, 7'h71, 8,  16'hFBA3, 4'hF, 4'h0, 1);
    vecs[5]  = mk(4'hD, 7'h00, 8,  16'hFBA3, 4'hD, 4'h2, 0);
    vecs[6]  = mk(4'hC, 7'h06, 10, 16'hFBA3, 4'hD, 4'h2, 0);
    vecs[7]  = mk(4'hE, 7'h3F, 3,  16'hFBA3, 4'hD, 4'h2, 0);
    vecs[8]  = mk(4'hB, 7'h6D, 8,  16'hF5A3, 4'hD, 4'h2, 0);
    vecs[9]  = mk(4'hD, 7'h06, 8,  16'hF513, 4'hF, 4'h0, 0);
    vecs[10] = mk(4'hE, 7'h79, 8,  16'hF51E, 4'hF, 4'h0, 0);
    vecs[11] = mk(4'h7, 7'h39, 8,  16'hC51E, 4'hF, 4'h0, 1);
    vecs[12] = mk(4'h7, 7'h5E, 8,  16'hD51E, 4'hF, 4'h0, 0);
    vecs[13] = mk(4'hE, 7'h4F, 8,  16'h0003, 4'h1, 4'h0, 0);
    vecs[14] = mk(4'hD, 7'h77, 8,  16'h00A3, 4'h3, 4'h0, 0);
    vecs[15] = mk(4'hB, 7'h7C, 8,  16'h0BA3, 4'h7, 4'h0, 0);
    vecs[16] = mk(4'h7, 7'h71, 8,  16'hFBA3, 4'hF, 4'h0, 1);

    reset   = 1'b1;
    bus.an  = 4'hF;
    bus.seg = 7'h7F;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hex", 32'(bus.hex), 32'h0);
    check("reset_valid", 32'(bus.digit_valid), 32'h0);
    check("reset_err", 32'(bus.err), 32'h0);
    check("reset_frame_done", 32'(bus.frame_done), 32'h0);

    // Exact acceptance latency: outputs change on the 7th edge (k+6).
    reset   = 1'b0;
    bus.an  = 4'hE;
    bus.seg = ~7'h06;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("latency_hex_edge%0d", j), 32'(bus.hex), (j >= 6) ? 32'h1 : 32'h0);
      check($sformatf("latency_valid_edge%0d", j), 32'(bus.digit_valid), (j >= 6) ? 32'h1 : 32'h0);
    end

    for (int i = 0; i <= 12; i++) run_vec(i);

    // Reset during TRACK of digit 2 abandons the capture.
    bus.an  = 4'hB;
    bus.seg = ~7'h7C;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset_hex", 32'(bus.hex), 32'h0);
    check("midreset_valid", 32'(bus.digit_valid), 32'h0);
    check("midreset_err", 32'(bus.err), 32'h0);
    check("midreset_frame_done", 32'(bus.frame_done), 32'h0);
    reset = 1'b0;

    for (int i = 13; i <= 16; i++) run_vec(i);

    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_capture.md
SEVEN_SEG_CAPTURE -- requirements
Module: seven_seg_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, range 2..15; consecutive identical synchronized samples required to accept a digit.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 an  input  4  digit enables, active-low; an[i]=0 selects digit i.
REQ-005 seg  input  7  segment lines, active-low; seg[0]=a, seg[1]=b, ... seg[6]=g.
REQ-006 hex  output  16  recovered digits; digit i in hex[4i+3:4i].
REQ-007 digit_valid  output  4  bit i=1: hex digit i holds a legally decoded value.
REQ-008 err  output  4  bit i=1: last accepted pattern on digit i was not a legal glyph.
REQ-009 frame_done  output  1  one-cycle pulse when all four digits have been accepted since the previous pulse.

Function
REQ-010 The block SHALL pass an and seg through a 2-flop synchronizer; all further logic SHALL use only the synchronized values.
REQ-011 The block SHALL decode with the inverted active-high pattern {g..a}: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-012 The FSM SHALL have states IDLE, TRACK, LOCKED.
REQ-013 IDLE: when synchronized an has exactly one bit low, go to TRACK with stability count=1 and store the (an,seg) pair.
REQ-014 In any state, an with zero or more than one bit low SHALL force IDLE and clear the count; no capture occurs.
REQ-015 TRACK: same pair as stored -> count+1; different legal pair -> store it, count=1, remain in TRACK.
REQ-016 TRACK: when count reaches STABLE_CYCLES, accept the digit and go to LOCKED on the same edge.
REQ-017 Accept, legal glyph: SHALL write the nibble to hex digit i, set digit_valid[i], and clear err[i].
REQ-018 Accept, illegal glyph: SHALL set err[i], clear digit_valid[i], and leave hex digit i unchanged.
REQ-019 LOCKED: an unchanged pair SHALL produce no further acceptance; a changed legal pair -> TRACK with count=1.
REQ-020 Latency: a pair first sampled at input edge k and held SHALL update outputs at edge k+STABLE_CYCLES+2 exactly (k+6 at default).
REQ-021 An internal seen[3:0] mask SHALL OR in bit i on every acceptance, whether legal or illegal.
REQ-022 When an acceptance makes seen==4'hF, seen SHALL clear on that edge and frame_done SHALL assert for exactly the following cycle.
REQ-023 Re-accepting an already-seen digit SHALL NOT advance the frame; frame_done SHALL NOT assert twice without four distinct fresh acceptances.
REQ-024 A glitch shorter than STABLE_CYCLES SHALL NOT change any output; the count restarts per REQ-015.
REQ-025 The stability counter SHALL saturate at STABLE_CYCLES and never wrap.

Reset
REQ-026 While reset=1: hex=16'h0000, digit_valid=4'b0000, err=4'b0000, frame_done=0, seen=0, count=0, synchronizers=all ones, state=IDLE.
REQ-027 Reset asserted mid-TRACK or mid-LOCKED SHALL abandon the pending capture; after deassertion, behaviour SHALL match a fresh start.

Verification
REQ-028 an=1110, seg=~7'h06 held 10 cycles after reset -> at edge 6: hex[3:0]=1, digit_valid=0001, err=0000.
REQ-029 Scan digits 0..3 with glyphs 3,A,b,F, each held 8 cycles -> hex=16'hFbA3, digit_valid=1111, frame_done high exactly one cycle after the digit-3 acceptance.
REQ-030 Digit 1 shows seg=~7'h00 (blank) for 8 cycles -> err=0010, digit_valid[1]=0, hex[7:4] retains its previous value.
REQ-031 Pattern held 3 cycles then changed, STABLE_CYCLES=4 -> no output change, FSM remains in TRACK.
REQ-032 an=1100 for 10 cycles -> no acceptance, outputs unchanged, FSM in IDLE.
REQ-033 Reset pulsed one cycle during TRACK of digit 2 -> all outputs zero, no frame_done; the subsequent full scan completes normally.
